// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator slice.
//   - FSM state encoding (ST_ACCUM, ST_HOLD)
//   - default datapath widths used by the interface
//   - the saturating-add width rule: one guard bit above the accumulator
package product_accumulator_pkg;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  // Width of the intermediate sum: the extra top bit flags saturation.
  function automatic int sat_sum_w(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier side, the accumulator and the consumer.
//   in_valid/in_ready/in_product : product stream into the accumulator
//   clear                        : synchronous abort of the current group
//   out_valid/out_ready          : result handshake
//   out_sum/out_overflow         : accumulated (saturated) result and its flag
// modport slave  : the accumulator itself
// modport master : the environment around it (upstream + consumer)
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  modport slave (
    input  in_valid, in_product, clear, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );

  modport master (
    output in_valid, in_product, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating adder: acc + zero-extended addend.
//   acc    : current accumulator value (ACC_W bits)
//   addend : unsigned product (PROD_W bits, PROD_W <= ACC_W)
//   sum    : acc + addend, clamped to all-ones on overflow
//   ovf    : 1 when the clamp was applied
module product_accumulator_sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W  = 12,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int SUM_W = sat_sum_w(ACC_W);

  logic [SUM_W-1:0] wide;

  // Clamp a guard-bit-extended sum back to ACC_W bits.
  function automatic logic [ACC_W-1:0] saturate(input logic [SUM_W-1:0] w);
    return w[ACC_W] ? {ACC_W{1'b1}} : w[ACC_W-1:0];
  endfunction

  always_comb begin
    wide = SUM_W'(acc) + SUM_W'(addend);
    sum  = saturate(wide);
    ovf  = wide[ACC_W];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive unsigned products into one saturated result.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : product_accumulator_if.slave (input stream, clear, result handshake)
// ACCUM accepts products; the COUNT-th accept moves to HOLD, where the result
// is presented until out_ready. clear aborts the group from either state.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  localparam int              CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             in_accum;

  product_accumulator_sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .acc    (acc_q),
    .addend (bus.in_product),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  assign in_accum = (state_q == ST_ACCUM);
  assign accept   = bus.in_valid && in_accum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      // Any product offered alongside clear is handshaken but discarded.
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (in_accum) begin
      if (accept) begin
        acc_d = add_sum;
        ovf_d = ovf_q | add_ovf;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (bus.out_ready) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result is only exposed in HOLD; the running partial sum stays hidden.
  assign bus.in_ready     = in_accum;
  assign bus.out_valid    = ~in_accum;
  assign bus.out_sum      = in_accum ? '0 : acc_q;
  assign bus.out_overflow = ~in_accum & ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if0 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if1 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if2 ();

  product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(9),  .COUNT(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.in_valid = 0; if0.in_product = 0; if0.clear = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.in_product = 0; if1.clear = 0; if1.out_ready = 1;
    if2.in_valid = 0; if2.in_product = 0; if2.clear = 0; if2.out_ready = 1;
    #3;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready); end
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
    n_cmp++; if (if0.out_sum !== 12'd0) begin n_bad++; $display("FAIL reset_out_sum: got %0d want 0", if0.out_sum); end
    n_cmp++; if (if0.out_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_out_overflow: got %b want 0", if0.out_overflow); end
    n_cmp++; if ({if1.in_ready, if1.out_valid, if2.in_ready, if2.out_valid} !== 4'b1010) begin
      n_bad++; $display("FAIL reset_other_duts: got %b want 1010", {if1.in_ready, if1.out_valid, if2.in_ready, if2.out_valid});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] prods [4];
    prods = '{8'd6, 8'd15, 8'd225, 8'd0};
    if0.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1; if0.in_product = prods[i];
      n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL basic_accum_%0d: out_valid=%b in_ready=%b want 0/1", i, if0.out_valid, if0.in_ready);
      end
      step();
    end
    if0.in_valid = 0;
    n_cmp++; if (if0.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b want 1", if0.out_valid); end
    n_cmp++; if (if0.out_sum !== 12'd246) begin n_bad++; $display("FAIL basic_sum: got %0d want 246", if0.out_sum); end
    n_cmp++; if (if0.out_overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", if0.out_overflow); end
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_hold: got %b want 0", if0.in_ready); end
    step();
    n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.out_sum !== 12'd0) begin
      n_bad++; $display("FAIL basic_after_hs: out_valid=%b in_ready=%b sum=%0d want 0/1/0", if0.out_valid, if0.in_ready, if0.out_sum);
    end
  endtask

  task automatic test_saturate();
    if1.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1; if1.in_product = 8'd225;
      step();
    end
    if1.in_valid = 0;
    n_cmp++; if (if1.out_valid !== 1'b1) begin n_bad++; $display("FAIL sat_out_valid: got %b want 1", if1.out_valid); end
    n_cmp++; if (if1.out_sum !== 9'd511) begin n_bad++; $display("FAIL sat_sum: got %0d want 511", if1.out_sum); end
    n_cmp++; if (if1.out_overflow !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", if1.out_overflow); end
    step();
    // Next group must start with a cleared overflow flag.
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1; if1.in_product = 8'd1;
      step();
    end
    if1.in_valid = 0;
    n_cmp++; if (if1.out_sum !== 9'd4 || if1.out_overflow !== 1'b0) begin
      n_bad++; $display("FAIL sat_next_group: sum=%0d ovf=%b want 4/0", if1.out_sum, if1.out_overflow);
    end
    step();
  endtask

  task automatic test_backpressure();
    if0.out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      if0.in_valid = 1; if0.in_product = 8'(i);
      step();
    end
    if0.in_valid = 1; if0.in_product = 8'd9;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0 || if0.out_sum !== 12'd10) begin
        n_bad++; $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%0d want 1/0/10", i, if0.out_valid, if0.in_ready, if0.out_sum);
      end
      step();
    end
    if0.out_ready = 1;
    step();
    n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_after_hs: out_valid=%b in_ready=%b want 0/1", if0.out_valid, if0.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_early_valid_%0d: got %b want 0", i, if0.out_valid); end
      end
      step();
    end
    if0.in_valid = 0;
    n_cmp++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'd36) begin
      n_bad++; $display("FAIL bp_next_sum: out_valid=%b sum=%0d want 1/36", if0.out_valid, if0.out_sum);
    end
    step();
  endtask

  task automatic test_clear();
    if0.out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      if0.in_valid = 1; if0.in_product = 8'd100;
      step();
    end
    if0.clear = 1; if0.in_product = 8'd100;
    step();
    if0.clear = 0;
    for (int i = 1; i <= 4; i++) begin
      if0.in_valid = 1; if0.in_product = 8'(i);
      n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_early_valid_%0d: got %b want 0", i, if0.out_valid); end
      if (i == 4) if0.out_ready = 0;
      step();
    end
    if0.in_valid = 0;
    n_cmp++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'd10) begin
      n_bad++; $display("FAIL clear_sum: out_valid=%b sum=%0d want 1/10", if0.out_valid, if0.out_sum);
    end
    // Clear while a result is pending discards it.
    if0.clear = 1;
    step();
    if0.clear = 0;
    n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL clear_hold: out_valid=%b in_ready=%b want 0/1", if0.out_valid, if0.in_ready);
    end
    if0.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1; if0.in_product = 8'd5;
      step();
    end
    if0.in_valid = 0;
    n_cmp++; if (if0.out_sum !== 12'd20) begin n_bad++; $display("FAIL clear_hold_next: got %0d want 20", if0.out_sum); end
    step();
  endtask

  task automatic test_async_reset();
    if0.out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      if0.in_valid = 1; if0.in_product = 8'd50;
      step();
    end
    if0.in_valid = 0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if0.out_sum !== 12'd0) begin
      n_bad++; $display("FAIL arst_mid: in_ready=%b out_valid=%b sum=%0d want 1/0/0", if0.in_ready, if0.out_valid, if0.out_sum);
    end
    step();
    rst = 1'b0;
    if0.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1; if0.in_product = 8'd50;
      step();
    end
    if0.in_valid = 0;
    n_cmp++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'd200) begin
      n_bad++; $display("FAIL arst_next_sum: out_valid=%b sum=%0d want 1/200", if0.out_valid, if0.out_sum);
    end
    // Reset between edges must drop a pending result at once.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.out_sum !== 12'd0) begin
      n_bad++; $display("FAIL arst_hold: out_valid=%b in_ready=%b sum=%0d want 0/1/0", if0.out_valid, if0.in_ready, if0.out_sum);
    end
    step();
    rst = 1'b0;
    if0.out_ready = 1;
    step();
  endtask

  task automatic test_count1();
    if2.out_ready = 1;
    if2.in_valid = 1; if2.in_product = 8'd7;
    step();
    n_cmp++; if (if2.out_valid !== 1'b1 || if2.out_sum !== 12'd7 || if2.in_ready !== 1'b0 || if2.out_overflow !== 1'b0) begin
      n_bad++; $display("FAIL c1_first: valid=%b sum=%0d in_ready=%b ovf=%b want 1/7/0/0", if2.out_valid, if2.out_sum, if2.in_ready, if2.out_overflow);
    end
    if2.in_product = 8'd8;
    step();
    n_cmp++; if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL c1_gap: out_valid=%b in_ready=%b want 0/1", if2.out_valid, if2.in_ready);
    end
    step();
    if2.in_valid = 0;
    n_cmp++; if (if2.out_valid !== 1'b1 || if2.out_sum !== 12'd8) begin
      n_bad++; $display("FAIL c1_second: valid=%b sum=%0d want 1/8", if2.out_valid, if2.out_sum);
    end
    step();
    n_cmp++; if (if2.out_valid !== 1'b0) begin n_bad++; $display("FAIL c1_idle: got %b want 0", if2.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_count1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Sequential stage directly downstream of the 4x4 binary multiplier. It consumes a stream of 8-bit unsigned products over a valid/ready handshake and sums COUNT consecutive products into one accumulated result, which it presents on an output valid/ready handshake. Typical use: dot-product / MAC tail behind the combinational multiplier, with the multiplier output registered into in_product.

Parameters:
PROD_W, 8, width of the incoming product (matches the 4x4 multiplier output).
ACC_W, 12, accumulator and result width; legal range is PROD_W..32.
COUNT, 4, number of products summed per result; legal range is 1..255.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_product is valid this cycle
in_ready  out  1  block accepts a product this cycle
in_product  in  PROD_W  unsigned product from the multiplier
clear  in  1  synchronous abort of the current group
out_valid  out  1  out_sum and out_overflow are valid
out_ready  in  1  consumer accepts the result
out_sum  out  ACC_W  accumulated sum, saturated to the maximum value
out_overflow  out  1  saturation occurred within this group

Behaviour:
- Reset (async assert, sync use after deassert):
  - state goes to ACCUM; acc, cnt and ovf are 0.
  - in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready.
  - On accept: acc <= sat(acc + zero-extended in_product). Sum is computed at ACC_W+1 bits.
  - If bit ACC_W is set: acc <= all-ones and ovf <= 1 (sticky for the group).
  - cnt increments on each accept.
  - On the COUNT-th accept: go to HOLD next cycle and reset cnt to 0. The result includes that product.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum=acc and out_overflow=ovf, stable until the handshake.
  - On out_valid && out_ready: acc<=0, ovf<=0, go to ACCUM. No new product is accepted in the handshake cycle.
- Latency: out_valid rises exactly 1 cycle after the COUNT-th accept. Sustained throughput is COUNT+1 cycles per result when out_ready is held high.
- out_sum and out_overflow are registered (driven from acc/ovf). Both read 0 in ACCUM.
- clear: synchronous and highest priority after rst.
  - In any state: acc, cnt and ovf go to 0 and state goes to ACCUM.
  - A product presented in the same cycle is dropped. in_ready stays as defined for the current state, so the upstream sees an accept, but the data is discarded.
  - A result pending in HOLD is discarded.
- COUNT=1: every accepted product goes straight to HOLD. out_sum equals the product, out_overflow=0 unless ACC_W < PROD_W (illegal).
- Backpressure: in_valid while in HOLD is ignored. The upstream must hold its data (standard valid/ready rules). in_valid may deassert between accepts with no effect on cnt.
- cnt width: clog2(COUNT+1). No wrap occurs because cnt is reset on the COUNT-th accept.
- Reset asserted mid-group: the partial sum is lost and no out_valid is produced.

Decomposition:
- Shared package: state encoding constants (ST_ACCUM, ST_HOLD) and the saturating-add width rule (ACC_W+1 intermediate).
- One natural sub-module: sat_adder (combinational, parameterised ACC_W/PROD_W, outputs sum and ovf). The FSM, counter and registers stay in the top module.

Test Plan:
- Defaults; in_valid held with products 6,15,225,0; out_ready=1 -> out_valid for 1 cycle, 1 cycle after the 4th accept; out_sum=246, out_overflow=0; in_ready=0 during that cycle.
- ACC_W=9; products 225,225,225,225 -> out_sum=511, out_overflow=1 (saturates on the 3rd add).
- Result ready but out_ready=0 for 5 cycles, in_valid=1 with 9 -> out_valid held, out_sum stable, in_ready=0, no accept; the first 9 is accepted the cycle after the handshake, and the next result excludes stale data.
- clear pulsed after 2 accepts of 100,100, then products 1,2,3,4 -> out_sum=10 (partial sum discarded).
- rst asserted asynchronously mid-group (between clock edges) -> outputs reach 0 and in_ready=1 immediately; the following 4 products of 50 give out_sum=200.
- COUNT=1, products 7 then 8, out_ready=1 -> two results, 7 then 8, each 1 cycle after its accept; accepts spaced 2 cycles apart.
